// File: rtl/fmul_rr_scheduler.sv
// Round-robin arbiter sharing one fmul datapath between NREQ requesters.
// Define FMUL_SCHED_PIPE_EN to add an EXEC2 state for a registered fmul.
module fmul_rr_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int NREQ       = 4,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_b_i,
  output logic [DATA_WIDTH-1:0]    mul_a_o,
  output logic [DATA_WIDTH-1:0]    mul_b_o,
  input  logic [DATA_WIDTH-1:0]    mul_c_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     busy_o
);

`ifdef FMUL_SCHED_PIPE_EN
  typedef enum logic [1:0] {
    IDLE, EXEC, EXEC2, RESP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, EXEC, RESP
  } state_t;
`endif

  state_t state, state_nx;

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       id_q;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  found;
  logic [ID_W-1:0]       gnt_id;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  sample;

  // first valid at or after ptr, wrapping modulo NREQ
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_a = req_a_i[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    sel_b = req_b_i[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (found) state_nx = EXEC;
`ifdef FMUL_SCHED_PIPE_EN
      EXEC:  state_nx = EXEC2;
      EXEC2: state_nx = RESP;
`else
      EXEC:  state_nx = RESP;
`endif
      RESP:  if (rsp_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && found)
      req_ready_o[gnt_id] = 1'b1;
    busy_o      = (state != IDLE);
    rsp_valid_o = (state == RESP);
`ifdef FMUL_SCHED_PIPE_EN
    sample      = (state == EXEC2);
`else
    sample      = (state == EXEC);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= '0;
      id_q     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rsp_data <= '0;
    end else begin
      if (state == IDLE && found) begin
        op_a <= sel_a;
        op_b <= sel_b;
        id_q <= gnt_id;
      end
      if (sample)
        rsp_data <= mul_c_i;
      if (state == RESP && rsp_ready_i) begin
        if (id_q == ID_W'(NREQ-1)) ptr <= '0;
        else                       ptr <= id_q + 1'b1;
      end
    end
  end

  assign mul_a_o    = op_a;
  assign mul_b_o    = op_b;
  assign rsp_data_o = rsp_data;
  assign rsp_id_o   = id_q;

endmodule
